// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg
//   Shared helpers for the RAM-based FIFO: a ceiling-log2 function, the
//   width of the fill-level counter, and a range check for the
//   almost-full / almost-empty thresholds.
//   No ports (package).
package ram_fifo_pkg;

  // Smallest n with 2**n >= v (returns 0 for v <= 1).
  function automatic int clog2(input int v);
    int n;
    n = 0;
    while ((1 << n) < v) n++;
    return n;
  endfunction

  // The level counter must represent 0..DEPTH, one bit wider than the address.
  function automatic int lvl_w(input int addr_w);
    return addr_w + 1;
  endfunction

  // almost_full threshold must be 1..DEPTH, almost_empty threshold 0..DEPTH-1.
  function automatic bit th_ok(input int addr_w, input int afull_th, input int aempty_th);
    return (afull_th >= 1) && (afull_th <= (1 << addr_w)) &&
           (aempty_th >= 0) && (aempty_th < (1 << addr_w));
  endfunction

endpackage

// File: rtl/ram_fifo_sdp_ram.sv
// ram_fifo_sdp_ram
//   Simple dual-port RAM for the FIFO storage: one write port, one read
//   port with a registered output. A read and a write to the same address
//   in the same cycle return the old contents (read-before-write).
//   Contents are never reset so the array maps onto block RAM.
// Ports
//   clk    in   clock, rising edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable; q holds its value when low
//   raddr  in   read address
//   q      out  registered read data
module ram_fifo_sdp_ram #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  q
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Non-blocking read of the same array gives read-before-write on collision.
  always_ff @(posedge clk) begin
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/ram_fifo_lvl.sv
// ram_fifo_lvl
//   RAM-based synchronous FIFO with full 2**ADDR_W capacity, registered
//   fill level, programmable almost-full/almost-empty thresholds and
//   sticky overflow/underflow errors.
//   Optional feature macro: RAM_FIFO_FWFT_EN selects first-word-fall-through
//   output behaviour; when undefined the FIFO uses a standard 1-cycle read.
// Ports
//   clk, res_n            clock (rising edge), asynchronous active-low reset
//   shift_in, wdata       push request and data
//   shift_out             pop request
//   rdata, rvalid         read data; rvalid pulses after a pop (standard mode)
//   full, empty           level == DEPTH / no word available
//   almost_full/_empty    level >= AFULL_TH / level <= AEMPTY_TH
//   level                 stored word count 0..DEPTH
//   overflow, underflow   sticky refused push / refused pop
//   clear_err             synchronous clear of the sticky errors
module ram_fifo_lvl
  import ram_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ADDR_W    = 9,
  parameter int AFULL_TH  = 480,
  parameter int AEMPTY_TH = 32
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              shift_in,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              shift_out,
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow,
  input  logic              clear_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LW    = lvl_w(ADDR_W);
  localparam logic [ADDR_W:0] AFULL_LVL  = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AEMPTY_LVL = AEMPTY_TH[ADDR_W:0];

  if (!th_ok(ADDR_W, AFULL_TH, AEMPTY_TH)) begin : g_th_check
    $error("ram_fifo_lvl: threshold parameters out of range");
  end
  if (clog2(DEPTH + 1) != LW) begin : g_lw_check
    $error("ram_fifo_lvl: level width inconsistent with depth");
  end

  logic [ADDR_W:0]   wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]   wr_ptr_next, rd_ptr_next, level_next;
  logic              full_reg, empty_reg, afull_reg, aempty_reg;
  logic [ADDR_W:0]   level_reg;
  logic              ovf_reg, udf_reg;
  logic              push_ok, pop_ok;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic [WIDTH-1:0]  ram_q;

  always_comb begin
    pop_ok      = shift_out & ~empty_reg;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    push_ok     = shift_in & (~full_reg | pop_ok);
    wr_ptr_next = wr_ptr_reg + {{ADDR_W{1'b0}}, push_ok};
    rd_ptr_next = rd_ptr_reg + {{ADDR_W{1'b0}}, pop_ok};
    level_next  = wr_ptr_next - rd_ptr_next;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      afull_reg  <= 1'b0;
      aempty_reg <= 1'b1;
      ovf_reg    <= 1'b0;
      udf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
      empty_reg  <= (wr_ptr_next == rd_ptr_next);
      full_reg   <= (wr_ptr_next[ADDR_W] != rd_ptr_next[ADDR_W]) &&
                    (wr_ptr_next[ADDR_W-1:0] == rd_ptr_next[ADDR_W-1:0]);
      afull_reg  <= (level_next >= AFULL_LVL);
      aempty_reg <= (level_next <= AEMPTY_LVL);
      // A new error in the same cycle as clear_err keeps the flag set.
      if (shift_in && !push_ok) ovf_reg <= 1'b1;
      else if (clear_err)       ovf_reg <= 1'b0;
      if (shift_out && !pop_ok) udf_reg <= 1'b1;
      else if (clear_err)       udf_reg <= 1'b0;
    end
  end

  ram_fifo_sdp_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_reg[ADDR_W-1:0]),
    .wdata (wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .q     (ram_q)
  );

`ifdef RAM_FIFO_FWFT_EN
  // The RAM output register continuously tracks the head address, so the
  // head word is visible without a pop. When a push writes the very address
  // being read (FIFO empty after this cycle's pop), the RAM would return
  // stale data; the pushed word is then presented from a bypass register.
  logic             collide;
  logic             byp_reg;
  logic [WIDTH-1:0] byp_data_reg;

  assign ram_re    = 1'b1;
  assign ram_raddr = rd_ptr_next[ADDR_W-1:0];
  assign collide   = push_ok && (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_next[ADDR_W-1:0]);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      byp_reg      <= 1'b0;
      byp_data_reg <= '0;
    end else begin
      byp_reg <= collide;
      if (collide) byp_data_reg <= wdata;
    end
  end

  assign rdata  = empty_reg ? '0 : (byp_reg ? byp_data_reg : ram_q);
  assign rvalid = 1'b0;
`else
  // The RAM read register only updates on an accepted pop, so it already
  // holds its value otherwise; loaded_reg masks its undefined power-up
  // contents until the first pop after reset.
  logic loaded_reg;
  logic rvalid_reg;

  assign ram_re    = pop_ok;
  assign ram_raddr = rd_ptr_reg[ADDR_W-1:0];

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      loaded_reg <= 1'b0;
      rvalid_reg <= 1'b0;
    end else begin
      rvalid_reg <= pop_ok;
      if (pop_ok) loaded_reg <= 1'b1;
    end
  end

  assign rdata  = loaded_reg ? ram_q : '0;
  assign rvalid = rvalid_reg;
`endif

  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = afull_reg;
  assign almost_empty = aempty_reg;
  assign level        = level_reg;
  assign overflow     = ovf_reg;
  assign underflow    = udf_reg;

endmodule

// File: tb/tb_ram_fifo_lvl.sv
// tb_ram_fifo_lvl
//   Self-checking bench for ram_fifo_lvl (default parameters). A queue-based
//   model tracks the FIFO contents and errors; a compare process checks every
//   output on each falling clock edge, and directed scenarios add literal
//   expectations. Works with or without RAM_FIFO_FWFT_EN defined.
module tb_ram_fifo_lvl;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;

  logic              clk = 1'b0;
  logic              res_n = 1'b0;
  logic              shift_in = 1'b0;
  logic [WIDTH-1:0]  wdata = '0;
  logic              shift_out = 1'b0;
  logic              clear_err = 1'b0;
  logic [WIDTH-1:0]  rdata;
  logic              rvalid, full, empty, almost_full, almost_empty;
  logic [ADDR_W:0]   level;
  logic              overflow, underflow;

  int checks = 0;
  int failures = 0;

  ram_fifo_lvl #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .AFULL_TH(480), .AEMPTY_TH(32)
  ) dut (
    .clk(clk), .res_n(res_n), .shift_in(shift_in), .wdata(wdata),
    .shift_out(shift_out), .rdata(rdata), .rvalid(rvalid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .level(level), .overflow(overflow), .underflow(underflow),
    .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_rdata = '0;
  bit               m_rvalid = 1'b0;
  bit               m_ovf = 1'b0;
  bit               m_udf = 1'b0;

  always @(posedge clk or negedge res_n) begin
    bit pop_acc, push_acc;
    logic [WIDTH-1:0] popped;
    if (!res_n) begin
      mq.delete();
      m_rdata  = '0;
      m_rvalid = 1'b0;
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
    end else begin
      pop_acc  = shift_out && (mq.size() > 0);
      push_acc = shift_in && ((mq.size() < DEPTH) || pop_acc);
      m_rvalid = 1'b0;
      if (pop_acc) begin
        popped = mq.pop_front();
`ifndef RAM_FIFO_FWFT_EN
        m_rdata  = popped;
        m_rvalid = 1'b1;
`endif
      end
      if (push_acc) mq.push_back(wdata);
      if (shift_in && !push_acc) m_ovf = 1'b1;
      else if (clear_err)        m_ovf = 1'b0;
      if (shift_out && !pop_acc) m_udf = 1'b1;
      else if (clear_err)        m_udf = 1'b0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    int sz;
    logic [WIDTH-1:0] exp_rd;
    sz = mq.size();
`ifdef RAM_FIFO_FWFT_EN
    exp_rd = (sz > 0) ? mq[0] : '0;
`else
    exp_rd = m_rdata;
`endif
    chk("cyc_level", 32'(level), 32'(sz));
    chk("cyc_full", 32'(full), 32'(sz == DEPTH));
    chk("cyc_empty", 32'(empty), 32'(sz == 0));
    chk("cyc_afull", 32'(almost_full), 32'(sz >= 480));
    chk("cyc_aempty", 32'(almost_empty), 32'(sz <= 32));
    chk("cyc_rdata", 32'(rdata), 32'(exp_rd));
    chk("cyc_rvalid", 32'(rvalid), 32'(m_rvalid));
    chk("cyc_overflow", 32'(overflow), 32'(m_ovf));
    chk("cyc_underflow", 32'(underflow), 32'(m_udf));
  end

  // One clock cycle with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input logic si, input logic [WIDTH-1:0] wd, input logic so, input logic ce);
    shift_in  = si;
    wdata     = wd;
    shift_out = so;
    clear_err = ce;
    @(posedge clk);
    #1;
    shift_in  = 1'b0;
    shift_out = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < DEPTH + 8 && !empty; n++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("drain_empty", 32'(empty), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] v;
    // Reset state
    repeat (3) @(posedge clk);
    #1 res_n = 1'b1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_rdata", 32'(rdata), 32'd0);

    // 1: push 1..5, pop 5 in order
    for (int i = 1; i <= 5; i++) begin
      v = 8'(i);
      cyc(1'b1, v, 1'b0, 1'b0);
    end
    chk("s1_level5", 32'(level), 32'd5);
    for (int i = 1; i <= 5; i++) begin
`ifdef RAM_FIFO_FWFT_EN
      chk("s1_rdata", 32'(rdata), 32'(i));
      cyc(1'b0, '0, 1'b1, 1'b0);
`else
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("s1_rdata", 32'(rdata), 32'(i));
      chk("s1_rvalid", 32'(rvalid), 32'd1);
`endif
    end
    chk("s1_empty", 32'(empty), 32'd1);
    chk("s1_level0", 32'(level), 32'd0);
    chk("s1_noerr", 32'({overflow, underflow}), 32'd0);

    // 2: fill to DEPTH, extra push overflows
    for (int i = 0; i < DEPTH; i++) begin
      v = 8'(i);
      cyc(1'b1, v, 1'b0, 1'b0);
    end
    chk("s2_full", 32'(full), 32'd1);
    chk("s2_level", 32'(level), 32'd512);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("s2_overflow", 32'(overflow), 32'd1);
    chk("s2_level_hold", 32'(level), 32'd512);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("s2_ovf_clear", 32'(overflow), 32'd0);

    // 3: simultaneous push+pop while full
    for (int k = 0; k < 10; k++) begin
      v = 8'(8'hA0 + k);
      cyc(1'b1, v, 1'b1, 1'b0);
      chk("s3_level", 32'(level), 32'd512);
    end
`ifdef RAM_FIFO_FWFT_EN
    chk("s3_head", 32'(rdata), 32'd10);
`else
    chk("s3_last_pop", 32'(rdata), 32'd9);
`endif
    chk("s3_no_ovf", 32'(overflow), 32'd0);
    drain();

    // 4: underflow on empty, clear_err vs new error
    r_hold = rdata;
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("s4_underflow", 32'(underflow), 32'd1);
    chk("s4_rdata_hold", 32'(rdata), 32'(r_hold));
    cyc(1'b0, '0, 1'b1, 1'b1);
    chk("s4_err_wins", 32'(underflow), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("s4_udf_clear", 32'(underflow), 32'd0);

    // 5: almost_full / almost_empty thresholds
    for (int i = 0; i < 479; i++) begin
      v = 8'(i * 3);
      cyc(1'b1, v, 1'b0, 1'b0);
    end
    chk("s5_afull_479", 32'(almost_full), 32'd0);
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    chk("s5_afull_480", 32'(almost_full), 32'd1);
    chk("s5_level480", 32'(level), 32'd480);
    for (int i = 0; i < 447; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("s5_level33", 32'(level), 32'd33);
    chk("s5_aempty_33", 32'(almost_empty), 32'd0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("s5_aempty_32", 32'(almost_empty), 32'd1);
    drain();

    // 6: pointer wrap, then async reset with data stored
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 300; i++) begin
        v = 8'(i + r);
        cyc(1'b1, v, 1'b0, 1'b0);
      end
      for (int i = 0; i < 300; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 17; i++) begin
      v = 8'(8'h30 + i);
      cyc(1'b1, v, 1'b0, 1'b0);
    end
    chk("s6_level17", 32'(level), 32'd17);
    res_n = 1'b0;
    #2;
    chk("s6_rst_empty", 32'(empty), 32'd1);
    chk("s6_rst_level", 32'(level), 32'd0);
    chk("s6_rst_aempty", 32'(almost_empty), 32'd1);
    chk("s6_rst_flags", 32'({full, almost_full, overflow, underflow, rvalid}), 32'd0);
    chk("s6_rst_rdata", 32'(rdata), 32'd0);
    @(posedge clk);
    #1 res_n = 1'b1;
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
`ifdef RAM_FIFO_FWFT_EN
    chk("s6_post_head", 32'(rdata), 32'h5A);
    cyc(1'b0, '0, 1'b1, 1'b0);
`else
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("s6_post_pop", 32'(rdata), 32'h5A);
`endif
    chk("s6_post_empty", 32'(empty), 32'd1);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
